l1_buffer_ctrl: RTL
===================

Name: l1_buffer_ctrl

Overview:
Pointer and sequencing controller for the per-pixel L1 BCID buffer, a dual-port SRAM FIFO.
- Generates the write address (wrAddr) and the L1A strobe for the buffer write side.
- Runs the read-side FSM: drives rdEn/rdAddr and presents buffered BCIDs to the downstream frame builder with a valid/ready handshake.
- Tracks occupancy, including writes still in flight, and drops L1As when the buffer is full.

Parameters:
- ADDRWIDTH, 7, buffer address width; DEPTH = 2^ADDRWIDTH entries.
- WR_DELAY, 3, clk cycles from an accepted L1A to the write committing into SRAM; committed wrAddr advances after this delay.

Ports:
- clk  in  1  40 MHz clock.
- reset  in  1  Synchronous, active-low reset.
- l1a_in  in  1  L1A request, one cycle per trigger, synchronous to clk.
- l1a_out  out  1  Qualified L1A to buffer write side; = l1a_in & ~full, combinational.
- wrAddr  out  ADDRWIDTH  Committed write pointer to buffer.
- rdAddr  out  ADDRWIDTH  Read pointer to buffer.
- rdEn  out  1  Buffer read enable, registered.
- bcid_in  in  12  Buffer QA output.
- dout  out  12  BCID presented downstream.
- dout_valid  out  1  dout holds an unread BCID.
- dout_ready  in  1  Downstream accepts dout.
- full  out  1  occupancy == DEPTH.
- empty  out  1  committed count == 0 and FSM in IDLE.
- occupancy  out  ADDRWIDTH+1  Accepted-minus-consumed entries, in-flight writes included.
- ovf_cnt  out  8  Dropped-L1A counter.

Behaviour:
Reset:
- All outputs 0: wrAddr, rdAddr, occupancy, ovf_cnt, rdEn, dout_valid, dout.
- full=0, empty=1.
- Write-delay pipeline flushed.
- FSM enters IDLE.
- Reset mid-operation discards all in-flight writes and held data; the next event after release starts from address 0.

Write side:
- accept = l1a_in & ~full. full is the registered value from the previous cycle.
- accept shifts into a WR_DELAY-deep pipeline.
- When an accept exits the pipeline, wrAddr increments (mod DEPTH) and commit_cnt increments.

Occupancy:
- +1 on accept, -1 on downstream handshake (dout_valid & dout_ready).
- Both in the same cycle leaves it unchanged.
- Never exceeds DEPTH and never underflows.
- L1A arriving while full=1:
  - dropped: no l1a_out, no pointer or occupancy change;
  - ovf_cnt increments, saturating at 255.
- A read completing in the same cycle does not rescue the L1A; full is evaluated on the prior-cycle value.

Read FSM (IDLE, READ, VALID):
- IDLE: if commit_cnt > 0, set rdEn=1 and go to READ.
- READ: rdEn=1 for exactly this one cycle, rdAddr held. The SRAM captures on the clk edge ending READ. Next state VALID with dout <= bcid_in and dout_valid=1; rdEn drops to 0.
- VALID: dout and dout_valid held stable until dout_ready=1. On handshake:
  - rdAddr increments (mod DEPTH);
  - commit_cnt and occupancy decrement;
  - dout_valid=0;
  - next state IDLE.
- Latency: commit to dout_valid is 2 cycles minimum. Back-to-back throughput is one BCID per 3 cycles.

Wrap-around:
- Pointers wrap DEPTH-1 -> 0.
- full/empty derive from counters, never from pointer equality.

Optional Feature:
OVF_CNT_EN:
- Defined: ovf_cnt implemented as specified.
- Undefined: counter logic removed and ovf_cnt tied to 0; dropping behaviour is unchanged.

Test Plan:
1. Reset, single l1a_in at cycle 10, dout_ready=1:
   - wrAddr 0->1 at cycle 13;
   - rdEn=1 at cycle 14;
   - dout_valid=1 at cycle 15 with dout = bcid_in sampled at the edge ending cycle 14;
   - rdAddr=1 and occupancy=0 at cycle 16.
2. 128 consecutive L1As, dout_ready=0:
   - occupancy=128, full=1;
   - 129th and 130th L1A give l1a_out=0 and ovf_cnt=2; wrAddr wraps to 0.
3. Full buffer: L1A and handshake in the same cycle -> L1A dropped, occupancy=127, ovf_cnt +1.
4. dout_ready low for 20 cycles during VALID -> dout stable, no rdEn pulse, rdAddr unchanged.
5. Reset asserted 1 cycle after an L1A (in flight) -> after release wrAddr=0, occupancy=0, no rdEn pulse ever.
6. Build with OVF_CNT_EN undefined, overflow as in scenario 2 -> ovf_cnt=0, drops still occur.

Source files
------------

// File: rtl/l1_buffer_ctrl.sv
// l1_buffer_ctrl: write-pointer/read-FSM controller for the per-pixel L1 BCID SRAM FIFO.
// Define OVF_CNT_EN to implement the dropped-L1A counter; otherwise ovf_cnt is tied to 0.
module l1_buffer_ctrl #(
  parameter int ADDRWIDTH = 7,
  parameter int WR_DELAY  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 l1a_in,
  output logic                 l1a_out,
  output logic [ADDRWIDTH-1:0] wrAddr,
  output logic [ADDRWIDTH-1:0] rdAddr,
  output logic                 rdEn,
  input  logic [11:0]          bcid_in,
  output logic [11:0]          dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 full,
  output logic                 empty,
  output logic [ADDRWIDTH:0]   occupancy,
  output logic [7:0]           ovf_cnt
);
  localparam int DEPTH = 1 << ADDRWIDTH;
  typedef enum logic [1:0] {IDLE, READ, VALID} state_t;
  state_t               r_state;
  logic [WR_DELAY-2:0]  r_pipe;
  logic [ADDRWIDTH:0]   r_occ, r_commit;
  logic [ADDRWIDTH-1:0] r_wr, r_rd;
  logic                 r_rden, r_valid;
  logic [11:0]          r_dout;
  logic                 w_accept, w_hs, w_commit;
  // The final register stage is the wrAddr/commit update itself, giving WR_DELAY edges total.
  assign w_commit   = r_pipe[WR_DELAY-2];
  assign full       = r_occ == (ADDRWIDTH+1)'(DEPTH);
  assign w_accept   = l1a_in & ~full;
  assign w_hs       = r_valid & dout_ready;
  assign l1a_out    = w_accept;
  assign empty      = (r_commit == '0) && (r_state == IDLE);
  assign wrAddr     = r_wr;
  assign rdAddr     = r_rd;
  assign rdEn       = r_rden;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign occupancy  = r_occ;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pipe   <= '0;
      r_occ    <= '0;
      r_commit <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_rden   <= 1'b0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_pipe   <= (r_pipe << 1) | (WR_DELAY-1)'(w_accept);
      r_occ    <= r_occ + (ADDRWIDTH+1)'(w_accept) - (ADDRWIDTH+1)'(w_hs);
      r_commit <= r_commit + (ADDRWIDTH+1)'(w_commit) - (ADDRWIDTH+1)'(w_hs);
      r_wr     <= r_wr + ADDRWIDTH'(w_commit);
      case (r_state)
        IDLE: if (r_commit != '0) begin
          r_rden  <= 1'b1;
          r_state <= READ;
        end
        READ: begin
          r_rden  <= 1'b0;
          r_dout  <= bcid_in;
          r_valid <= 1'b1;
          r_state <= VALID;
        end
        VALID: if (dout_ready) begin
          r_valid <= 1'b0;
          r_rd    <= r_rd + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef OVF_CNT_EN
  logic [7:0] r_ovf;
  always_ff @(posedge clk) begin
    if (!reset) r_ovf <= '0;
    else if (l1a_in && full && !(&r_ovf)) r_ovf <= r_ovf + 1'b1;
  end
  assign ovf_cnt = r_ovf;
`else
  assign ovf_cnt = 8'd0;
`endif
endmodule
